// File: rtl/grey_word_packer_pkg.sv
// Shared definitions for the grey pixel path: pixel width, the legal
// word-width range and the byte-keep mask helper used by the packer.
package grey_word_packer_pkg;

  // Grey pixel width, common to the converter and the packer.
  localparam int GREY_W = 8;

  // Legal range for the number of pixels packed per output word.
  localparam int WORD_BYTES_MIN = 2;
  localparam int WORD_BYTES_MAX = 8;

  // State of the single-entry output register.
  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_e;

  // Byte-keep mask with ones in lanes 0..count and zeros above.
  function automatic logic [WORD_BYTES_MAX-1:0] keep_mask(input int count);
    logic [WORD_BYTES_MAX-1:0] mask;
    mask = '0;
    for (int i = 0; i < WORD_BYTES_MAX; i++) begin
      if (i <= count) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/grey_skid_reg.sv
// Single-entry output register with a valid/ready handshake. It reloads in
// the same cycle it hands a word off, so a continuous stream runs at one
// word per cycle; while stalled the held payload never changes.
module grey_skid_reg
  import grey_word_packer_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [PAYLOAD_W-1:0] load_payload,
  output logic                 can_load,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;

  // A new word may enter when the register is empty or is draining now.
  assign can_load    = (state_q == SKID_EMPTY) || out_ready;
  assign out_valid   = (state_q == SKID_FULL);
  assign out_payload = payload_q;

  // Next state and payload: load when empty, reload or drain when full.
  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path
    // leaves it unassigned; a missing default would infer a latch.
    state_d   = state_q;
    payload_d = payload_q;
    case (state_q)
      SKID_EMPTY: begin
        if (load) begin
          state_d   = SKID_FULL;
          payload_d = load_payload;
        end
      end
      SKID_FULL: begin
        if (out_ready) begin
          if (load) payload_d = load_payload;
          else      state_d   = SKID_EMPTY;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // State and payload registers; the payload resets so out_data reads 0.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples
    // the pre-edge values regardless of block evaluation order.
    if (rst) begin
      state_q   <= SKID_EMPTY;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/grey_word_packer.sv
// Packs the 8-bit grey pixel stream into WORD_BYTES-wide words for the
// frame-buffer write path, flushes a partial word at end of frame with a
// byte-keep mask, and reports per-frame word count and a sticky error.
module grey_word_packer
  import grey_word_packer_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [GREY_W-1:0]            in_grey,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [GREY_W*WORD_BYTES-1:0] out_data,
  output logic [WORD_BYTES-1:0]        out_keep,
  output logic                         out_last,
  output logic [CNT_W-1:0]             frame_words,
  output logic                         proto_err
);

  localparam int LANE_W = $clog2(WORD_BYTES);
  localparam int DATA_W = GREY_W * WORD_BYTES;
  localparam int ACC_W  = GREY_W * (WORD_BYTES - 1);
  localparam int PAY_W  = DATA_W + WORD_BYTES + 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  if (WORD_BYTES < WORD_BYTES_MIN || WORD_BYTES > WORD_BYTES_MAX) begin : g_word_bytes_illegal
    $error("grey_word_packer: WORD_BYTES outside the supported range");
  end

  logic [ACC_W-1:0]  acc_data_q, acc_data_d;
  logic [LANE_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  frame_words_q, frame_words_d;
  logic              proto_err_q, proto_err_d;
  logic              pend_q, pend_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] prev_data_q, prev_data_d;

  logic              can_load;
  logic              accept;
  logic              complete;
  logic              out_xfer;
  logic              stall;
  logic [DATA_W-1:0] load_data;
  logic [WORD_BYTES-1:0] load_keep;
  logic [PAY_W-1:0]  out_payload;

  // During reset the packer swallows input so upstream never stalls on it.
  assign in_ready = rst || can_load;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((acc_cnt_q == LAST_LANE) || in_last);
  assign out_xfer = out_valid && out_ready;
  assign stall    = out_valid && !out_ready;

  // Assemble the outgoing word: stored lanes, the new pixel, zeros above.
  always_comb begin
    load_keep = WORD_BYTES'(keep_mask(int'(acc_cnt_q)));
    load_data = '0;
    for (int i = 0; i < WORD_BYTES - 1; i++) begin
      if (LANE_W'(i) < acc_cnt_q)
        load_data[i*GREY_W +: GREY_W] = acc_data_q[i*GREY_W +: GREY_W];
    end
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (LANE_W'(i) == acc_cnt_q)
        load_data[i*GREY_W +: GREY_W] = in_grey;
    end
  end

  // Accumulator: store the pixel in its lane, or restart at lane 0 when the
  // word completes. Stale lanes are left in place; the keep mask hides them.
  always_comb begin
    acc_data_d = acc_data_q;
    acc_cnt_d  = acc_cnt_q;
    if (accept) begin
      if (complete) begin
        acc_cnt_d = '0;
      end else begin
        acc_cnt_d = acc_cnt_q + 1'b1;
        for (int i = 0; i < WORD_BYTES - 1; i++) begin
          if (LANE_W'(i) == acc_cnt_q)
            acc_data_d[i*GREY_W +: GREY_W] = in_grey;
        end
      end
    end
  end

  // Word counter: count handed-off words, publish the total on the last one.
  always_comb begin
    word_cnt_d    = word_cnt_q;
    frame_words_d = frame_words_q;
    if (out_xfer) begin
      if (out_last) begin
        frame_words_d = word_cnt_q + 1'b1;
        word_cnt_d    = '0;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // Protocol watch while stalled: a withdrawn pixel or a changing word.
  always_comb begin
    pend_d      = in_valid && !in_ready;
    stall_d     = stall;
    prev_data_d = out_data;
    proto_err_d = proto_err_q
                || (pend_q && !in_valid)
                || (stall_q && (out_data != prev_data_q));
  end

  // Control state; cleared by reset so a restarted frame begins at lane 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q     <= '0;
      word_cnt_q    <= '0;
      frame_words_q <= '0;
      proto_err_q   <= 1'b0;
      pend_q        <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      acc_cnt_q     <= acc_cnt_d;
      word_cnt_q    <= word_cnt_d;
      frame_words_q <= frame_words_d;
      proto_err_q   <= proto_err_d;
      pend_q        <= pend_d;
      stall_q       <= stall_d;
    end
  end

  // Data-only storage without reset.
  always_ff @(posedge clk) begin
    // NOTE: these registers need no reset: accumulator lanes are only
    // emitted after being written in the current word, and the previous
    // output copy is only compared when stall_q (which does reset) is set.
    acc_data_q  <= acc_data_d;
    prev_data_q <= prev_data_d;
  end

  grey_skid_reg #(
    .PAYLOAD_W (PAY_W)
  ) u_out_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (complete),
    .load_payload ({in_last, load_keep, load_data}),
    .can_load     (can_load),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_payload  (out_payload)
  );

  assign out_data    = out_payload[DATA_W-1:0];
  assign out_keep    = out_payload[DATA_W +: WORD_BYTES];
  assign out_last    = out_payload[PAY_W-1];
  assign frame_words = frame_words_q;
  assign proto_err   = proto_err_q;

endmodule
